dibit_packetizer: RTL and testbench

//  Upstream feeder for the RMII transmit tether. Accepts a byte stream with

---
 rtl/dibit_packetizer.sv | 149 ++++++++++++++
 tb/tb_dibit_packetizer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dibit_packetizer.sv
// Byte-stream to dibit burst packetizer: FIFO-buffered bytes leave as fixed-size,
// contiguous-valid dibit bursts separated by a forced idle gap.
module dibit_packetizer #(
  parameter int unsigned PKT_BYTES  = 22,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned GAP_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  output logic       axiir,
  input  logic       flush,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] len, len_n;
  logic [CW-1:0] byte_cnt, byte_cnt_n;
  logic [1:0]    dibit_idx, dibit_idx_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          flush_pending, flush_pending_n;
  logic          axiov_n;
  logic [1:0]    axiod_n;
  logic          push, pop;
  logic [7:0]    head;
  logic [1:0]    head_next_lo;

  assign axiir        = (count < CW'(FIFO_DEPTH));
  assign push         = axiiv & axiir;
  assign head         = mem[rd_ptr];
  assign head_next_lo = mem[rd_ptr + AW'(1)][1:0];

  // Byte storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= axiid;
    end
  end

  // State, pointers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      len           <= '0;
      byte_cnt      <= '0;
      dibit_idx     <= '0;
      gap_cnt       <= '0;
      flush_pending <= 1'b0;
      axiov         <= 1'b0;
      axiod         <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      wr_ptr        <= wr_ptr + AW'(push);
      rd_ptr        <= rd_ptr + AW'(pop);
      count         <= count + CW'(push) - CW'(pop);
      len           <= len_n;
      byte_cnt      <= byte_cnt_n;
      dibit_idx     <= dibit_idx_n;
      gap_cnt       <= gap_cnt_n;
      flush_pending <= flush_pending_n;
      axiov         <= axiov_n;
      axiod         <= axiod_n;
      busy          <= (state_n != IDLE);
    end
  end

  // Next-state logic; axiod_n looks one dibit ahead so the output register
  // always holds the dibit belonging to the current SEND cycle.
  always_comb begin
    state_n         = state;
    len_n           = len;
    byte_cnt_n      = byte_cnt;
    dibit_idx_n     = dibit_idx;
    gap_cnt_n       = gap_cnt;
    flush_pending_n = flush_pending | flush;
    pop             = 1'b0;
    axiov_n         = 1'b0;
    axiod_n         = 2'b00;

    case (state)
      IDLE: begin
        if (count == '0) begin
          flush_pending_n = flush;
        end
        if ((count >= CW'(PKT_BYTES)) || (flush_pending && (count != '0))) begin
          len_n       = (count > CW'(PKT_BYTES)) ? CW'(PKT_BYTES) : count;
          byte_cnt_n  = '0;
          dibit_idx_n = 2'd0;
          state_n     = SEND;
          axiov_n     = 1'b1;
          axiod_n     = head[1:0];
        end
      end

      SEND: begin
        axiov_n     = 1'b1;
        dibit_idx_n = dibit_idx + 2'd1;
        case (dibit_idx)
          2'd0: axiod_n = head[3:2];
          2'd1: axiod_n = head[5:4];
          2'd2: axiod_n = head[7:6];
          default: begin
            pop = 1'b1;
            if (byte_cnt == len - CW'(1)) begin
              state_n   = GAP;
              gap_cnt_n = '0;
              axiov_n   = 1'b0;
              axiod_n   = 2'b00;
            end else begin
              byte_cnt_n = byte_cnt + CW'(1);
              axiod_n    = head_next_lo;
            end
          end
        endcase
      end

      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dibit_packetizer.sv
// Self-checking bench for dibit_packetizer: a queue-based burst/gap reference model
// checks every output each cycle, plus directed burst-shape checks per scenario.
module tb_dibit_packetizer;

  localparam int unsigned PKT   = 22;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned GAPC  = 256;

  logic       clk;
  logic       rst;
  logic       axiiv;
  logic [7:0] axiid;
  logic       axiir;
  logic       flush;
  logic       axiov;
  logic [1:0] axiod;
  logic       busy;

  dibit_packetizer #(.PKT_BYTES(PKT), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAPC)) dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiir (axiir),
    .flush (flush),
    .axiov (axiov),
    .axiod (axiod),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes accepted but not yet sent, burst/quiet timing
  logic [7:0] mq[$];
  bit         m_valid    = 1'b0;
  bit         m_pend     = 1'b0;
  int         burst_left = 0;
  int         quiet      = 0;
  int         dib        = 0;
  int         n_acc      = 0;

  // Collectors of what the DUT actually emitted
  logic [1:0] cap[$];
  int         lens[$];
  int         cur_len = 0;

  int         size0;
  int         take;
  logic [1:0] exp_d;

  always @(negedge clk) begin
    size0 = mq.size();
    if (m_valid) begin
      check_eq("axiir", axiir, (size0 < DEPTH));
      check_eq("axiov", axiov, (burst_left > 0));
      check_eq("busy", busy, (burst_left > 0) || (quiet > 0));
      exp_d = 2'b00;
      if (burst_left > 0 && size0 > 0) exp_d = 2'(mq[0] >> (2 * dib));
      check_eq("axiod", axiod, exp_d);
    end

    if (axiov === 1'b1) begin
      cap.push_back(axiod);
      cur_len++;
    end else if (cur_len > 0) begin
      lens.push_back(cur_len);
      cur_len = 0;
    end

    if (rst === 1'b0) begin
      mq.delete();
      m_valid    = 1'b1;
      m_pend     = 1'b0;
      burst_left = 0;
      quiet      = 0;
      dib        = 0;
    end else if (m_valid) begin
      if (burst_left > 0) begin
        dib++;
        if (dib == 4) begin
          void'(mq.pop_front());
          dib = 0;
        end
        burst_left--;
        if (burst_left == 0) quiet = GAPC;
      end else if (quiet > 0) begin
        quiet--;
      end else begin
        if (size0 >= PKT || (m_pend && size0 > 0)) begin
          take       = (size0 > PKT) ? PKT : size0;
          burst_left = 4 * take;
          dib        = 0;
        end
        if (size0 == 0) m_pend = 1'b0;
      end
      if (flush) m_pend = 1'b1;
      if (axiiv && size0 < DEPTH) begin
        mq.push_back(axiid);
        n_acc++;
      end
    end
  end

  function automatic bit settled();
    return (burst_left == 0) && (quiet == 0) && (mq.size() < PKT) &&
           !(m_pend && mq.size() > 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    axiiv = 1'b1;
    axiid = d;
    tick();
    axiiv = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_settle(input string tag, input int budget);
    int n;
    n = 0;
    while (!settled() && n < budget) begin
      tick();
      n++;
    end
    tick();
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic cmp_stream(input string tag, input logic [7:0] q[$]);
    check_eq({tag, "_len"}, cap.size(), 4 * q.size());
    for (int i = 0; i < q.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        if (4 * i + j < cap.size()) check_eq(tag, cap[4 * i + j], (q[i] >> (2 * j)) & 8'd3);
      end
    end
  endtask

  task automatic clear_logs();
    cap.delete();
    lens.delete();
  endtask

  logic [7:0] tq[$];
  logic [1:0] t2_exp[12];
  logic [7:0] base;
  int         acc_start;
  int         i3;
  int         guard;
  bit         acc;
  bit         saw_full;

  initial begin
    rst   = 1'b0;
    axiiv = 1'b0;
    axiid = 8'h00;
    flush = 1'b0;
    idle_cycles(3);
    rst = 1'b1;
    check_eq("reset_axiov", axiov, 1'b0);
    check_eq("reset_axiod", axiod, 2'b00);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_axiir", axiir, 1'b1);

    // T1: 22 sequential bytes -> one 88-dibit burst
    clear_logs();
    tq.delete();
    for (int i = 0; i < 22; i++) begin
      tq.push_back(8'(i));
      push_byte(8'(i));
    end
    wait_settle("t1_settle", 600);
    check_eq("t1_nbursts", lens.size(), 1);
    if (lens.size() > 0) check_eq("t1_len", lens[0], 88);
    cmp_stream("t1_data", tq);

    // T2: short flush burst with known dibits
    clear_logs();
    t2_exp = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00,
               2'b11, 2'b11, 2'b11, 2'b11};
    push_byte(8'hA5);
    push_byte(8'h3C);
    push_byte(8'hFF);
    pulse_flush();
    wait_settle("t2_settle", 600);
    check_eq("t2_nbursts", lens.size(), 1);
    if (lens.size() > 0) check_eq("t2_len", lens[0], 12);
    for (int i = 0; i < 12; i++) begin
      if (i < cap.size()) check_eq("t2_dibit", cap[i], t2_exp[i]);
    end

    // T3: 100 bytes with axiiv held high, back-pressure honoured
    clear_logs();
    tq.delete();
    base      = 8'($urandom);
    acc_start = n_acc;
    saw_full  = 1'b0;
    i3        = 0;
    guard     = 0;
    while (i3 < 100 && guard < 5000) begin
      axiiv = 1'b1;
      axiid = base + 8'(i3);
      @(negedge clk);
      acc = axiir;
      tick();
      if (acc) begin
        tq.push_back(base + 8'(i3));
        i3++;
      end else begin
        saw_full = 1'b1;
      end
      guard++;
    end
    axiiv = 1'b0;
    check_eq("t3_pushed", i3, 100);
    check_eq("t3_saw_full", saw_full, 1'b1);
    check_eq("t3_accepted", n_acc - acc_start, 100);
    wait_settle("t3_settle", 3000);
    check_eq("t3_nbursts_pre", lens.size(), 4);
    pulse_flush();
    wait_settle("t3_settle_flush", 800);
    check_eq("t3_nbursts", lens.size(), 5);
    for (int i = 0; i < lens.size(); i++) check_eq("t3_len", lens[i], (i < 4) ? 88 : 48);
    cmp_stream("t3_data", tq);

    // T4: reset in the middle of a burst, then a clean burst
    for (int i = 0; i < 22; i++) push_byte(8'($urandom));
    guard = 0;
    while (cur_len < 40 && guard < 400) begin
      tick();
      guard++;
    end
    check_eq("t4_reached_dibit40", (cur_len >= 40), 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("t4_axiov", axiov, 1'b0);
    check_eq("t4_busy", busy, 1'b0);
    check_eq("t4_axiir", axiir, 1'b1);
    idle_cycles(3);
    clear_logs();
    tq.delete();
    for (int i = 0; i < 22; i++) begin
      tq.push_back(8'($urandom));
      push_byte(tq[i]);
    end
    wait_settle("t4_settle", 600);
    check_eq("t4_nbursts", lens.size(), 1);
    if (lens.size() > 0) check_eq("t4_len", lens[0], 88);
    cmp_stream("t4_data", tq);

    // T5: flush on an empty FIFO emits nothing and does not stay pending
    clear_logs();
    pulse_flush();
    idle_cycles(500);
    check_eq("t5_no_output", cap.size(), 0);
    push_byte(8'h5A);
    idle_cycles(300);
    check_eq("t5_no_stale_flush", cap.size(), 0);
    pulse_flush();
    wait_settle("t5_settle", 600);
    tq.delete();
    tq.push_back(8'h5A);
    cmp_stream("t5_data", tq);

    // T6: continuous pushes overlapping pops during SEND
    clear_logs();
    tq.delete();
    for (int i = 0; i < 52; i++) begin
      tq.push_back(8'($urandom));
      push_byte(tq[i]);
    end
    wait_settle("t6_settle", 2000);
    pulse_flush();
    wait_settle("t6_settle_flush", 800);
    check_eq("t6_nbursts", lens.size(), 3);
    for (int i = 0; i < lens.size(); i++) check_eq("t6_len", lens[i], (i < 2) ? 88 : 32);
    cmp_stream("t6_data", tq);

    // Random traffic with sporadic flushes, checked cycle by cycle by the model
    for (int i = 0; i < 4000; i++) begin
      axiiv = 1'($urandom_range(0, 1));
      axiid = 8'($urandom);
      flush = ($urandom_range(0, 199) == 0);
      tick();
    end
    axiiv = 1'b0;
    flush = 1'b0;
    pulse_flush();
    wait_settle("rand_settle", 3000);
    check_eq("rand_drained", mq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
